// File: rtl/dct_mac_sched.sv
// Single-multiplier 8-tap dot-product scheduler for a DCT row: streams sample/coefficient
// pairs from two synchronous RAMs, accumulates, then rounds, descales and saturates to 16 bits.
module dct_mac_sched #(
    parameter int DESCALE = 13,
    parameter int ACC_W   = 32
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_idle,
    output logic        ap_done,
    output logic        ap_ready,
    input  logic [2:0]  row,
    output logic [2:0]  src_address0,
    output logic        src_ce0,
    input  logic [14:0] src_q0,
    output logic [5:0]  coef_address0,
    output logic        coef_ce0,
    input  logic [15:0] coef_q0,
    output logic [15:0] dout,
    output logic        dout_ap_vld
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(1) << (DESCALE - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = 32767;
    localparam logic signed [ACC_W:0] SAT_MIN = -32768;

    state_t                    state, next_state;
    logic [2:0]                k;
    logic [2:0]                row_l;
    logic [1:0]                drain_cnt;
    logic                      data_vld;
    logic                      prod_vld;
    logic signed [28:0]        prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [30:0]        mult_full;
    logic                      mult_unused;
    logic signed [ACC_W:0]     rnd_sum;
    logic signed [ACC_W:0]     rnd_shift;
    logic [15:0]               sat;

    // The only multiplier; the top two product bits are dropped so the product wraps at 29 bits.
    assign mult_full   = $signed(src_q0) * $signed(coef_q0);
    assign mult_unused = ^mult_full[30:29];
    assign prod_ext    = {{(ACC_W-29){prod[28]}}, prod};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ap_start) next_state = ISSUE;
            ISSUE:   if (k == 3'd7) next_state = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ap_idle       = (state == IDLE);
        ap_done       = (state == DONE);
        ap_ready      = ap_done;
        dout_ap_vld   = ap_done;
        src_ce0       = (state == ISSUE);
        coef_ce0      = src_ce0;
        src_address0  = k;
        coef_address0 = {row_l, k};
    end

    // Extra headroom bit so the rounding offset cannot wrap a near-full-scale accumulator.
    always_comb begin
        rnd_sum   = {acc[ACC_W-1], acc} + RND;
        rnd_shift = rnd_sum >>> DESCALE;
        if (rnd_shift > SAT_MAX) begin
            sat = 16'h7fff;
        end else if (rnd_shift < SAT_MIN) begin
            sat = 16'h8000;
        end else begin
            sat = rnd_shift[15:0];
        end
    end

    // Pipeline: issue -> RAM data (data_vld) -> product register (prod_vld) -> accumulate.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            k         <= 3'd0;
            row_l     <= 3'd0;
            drain_cnt <= 2'd0;
            data_vld  <= 1'b0;
            prod_vld  <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            dout      <= 16'd0;
        end else begin
            data_vld <= (state == ISSUE);
            prod_vld <= data_vld;
            if (data_vld) begin
                prod <= mult_full[28:0];
            end
            if (state == IDLE && ap_start) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + prod_ext;
            end
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        row_l     <= row;
                        k         <= 3'd0;
                        drain_cnt <= 2'd0;
                    end
                end
                ISSUE: k <= k + 3'd1;
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) begin
                        dout <= sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dct_mac_sched.md
DCT_MAC_SCHED -- requirements
Module: dct_mac_sched

Interface
REQ-001 Parameter DESCALE, default 13, right-shift applied to the accumulator when forming dout.
REQ-002 Parameter ACC_W, default 32, signed accumulator width.
REQ-003 ap_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 ap_rst  in  1  reset, synchronous, active-high.
REQ-005 ap_start  in  1  request one 8-tap dot product.
REQ-006 ap_idle  out  1  high while in IDLE.
REQ-007 ap_done  out  1  one-cycle pulse when dout is valid.
REQ-008 ap_ready  out  1  one-cycle pulse, coincident with ap_done.
REQ-009 row  in  3  coefficient row index, sampled at start accept.
REQ-010 src_address0  out  3  sample read address k.
REQ-011 src_ce0  out  1  sample read enable.
REQ-012 src_q0  in  15  signed sample; valid one cycle after src_ce0.
REQ-013 coef_address0  out  6  coefficient address {row_latched, k}.
REQ-014 coef_ce0  out  1  coefficient read enable, identical to src_ce0.
REQ-015 coef_q0  in  16  signed coefficient; valid one cycle after coef_ce0.
REQ-016 dout  out  16  signed rounded, saturated result.
REQ-017 dout_ap_vld  out  1  identical to ap_done.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE when ap_start=1; ISSUE->DRAIN after k=7 issued; DRAIN->DONE after last accumulate; DONE->IDLE unconditionally.
REQ-019 Cycle C0 = IDLE cycle with ap_start=1; row latches at end of C0; accumulator clears to 0 at end of C0.
REQ-020 In cycles C1..C8, src_ce0=coef_ce0=1, src_address0=k=0..7, coef_address0={row,k}; both enables are 0 in all other cycles.
REQ-021 Data for k arrives at C(k+2); the product is registered at the end of that cycle; the accumulator adds it at the end of C(k+3).
REQ-022 Product = 15s x 16s, kept to 29 bits signed (wraps mod 2^29), then sign-extended to ACC_W; the accumulator wraps mod 2^ACC_W; exactly one multiplier instance is used.
REQ-023 In C11, res = (acc + 2^(DESCALE-1)) arithmetic-shifted right by DESCALE, then saturated to [-32768, 32767] and registered into dout.
REQ-024 In C12 (state DONE), ap_done=ap_ready=dout_ap_vld=1 for exactly one cycle; dout holds its value until the next C12.
REQ-025 Fixed latency: 12 cycles from C0 to ap_done; ap_start is ignored outside IDLE, and no overlap occurs.
REQ-026 ap_start high in the C12 cycle is not accepted; acceptance occurs at C13 (IDLE) if ap_start is still high.
REQ-027 ap_idle=1 only in IDLE, including the first cycle after reset.

Reset
REQ-028 When ap_rst=1, the next state is IDLE; dout=0, ap_done=ap_ready=dout_ap_vld=0, src_ce0=coef_ce0=0, addresses=0, accumulator=0, product register=0, ap_idle=1 after the edge.
REQ-029 Reset during any state aborts the operation with no ap_done pulse; reset has priority over ap_start.

Verification
REQ-030 Samples all 1, coef row 2 all 8192, row=2 -> coef_address0 = 16..23 in C1..C8; dout=8 with ap_done at C12.
REQ-031 Rounding: sample[0]=1, others 0; coef 4096 -> dout=1; coef 4095 -> dout=0; sample[0]=-1, coef 4097 -> dout=-1.
REQ-032 Saturation: samples all 16383, coefs all 16383 -> acc=2147221512 -> dout=32767; samples all -16383 with the same coefs -> dout=-32768.
REQ-033 Back-to-back: ap_start held high continuously -> accepts at C0 and C13; ap_done pulses at C12 and C25; ap_idle is low except in C13.
REQ-034 Reset asserted in C6 for 1 cycle -> no ap_done; ap_idle=1 next cycle; the next start produces a correct result independent of the aborted run.
REQ-035 Randomized: 1000 runs of random row, samples and coefs compared against a reference model per REQ-022/023; every run has exactly 12-cycle latency.
